// File: rtl/spi_ram_bridge_if.sv
// ---------------------------------------------------------------------------
// spi_ram_bridge_if
// Serial frame bus between an SPI-style master and spi_ram_bridge.
//   ss_n       master -> slave  frame select, active low
//   mosi       master -> slave  serial data in, MSB first
//   miso       slave  -> master serial read data (registered in the slave)
//   busy       slave  -> master high while the slave FSM is not idle
//   frame_err  slave  -> master one-cycle pulse when a frame is aborted
// ---------------------------------------------------------------------------
interface spi_ram_bridge_if;
    logic ss_n;
    logic mosi;
    logic miso;
    logic busy;
    logic frame_err;

    modport master (
        output ss_n,
        output mosi,
        input  miso,
        input  busy,
        input  frame_err
    );

    modport slave (
        input  ss_n,
        input  mosi,
        output miso,
        output busy,
        output frame_err
    );
endinterface

// File: rtl/spi_ram_bridge.sv
// ---------------------------------------------------------------------------
// spi_ram_bridge
// SPI-slave to single-port RAM bridge. A frame is 2 command bits followed by
// DATA_W payload bits (MSB first) while ss_n is low:
//   00 load write pointer, 01 write RAM word, 10 load read pointer,
//   11 shift RAM word out on miso.
// Pointers are ADDR_W bits, wrap naturally and optionally auto-increment.
// Ports:
//   clk  single clock (bit clock == system clock)
//   rst  synchronous active-high reset
//   bus  spi_ram_bridge_if.slave (ss_n, mosi in; miso, busy, frame_err out)
// Parameters: DATA_W word width, ADDR_W address width (<= DATA_W),
//             AUTO_INC 1 = pointer increments after each data access.
// ---------------------------------------------------------------------------
module spi_ram_bridge #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int AUTO_INC = 1
) (
    input  logic             clk,
    input  logic             rst,
    spi_ram_bridge_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WRITE,
        S_READ_PREP,
        S_READ_SHIFT,
        S_DONE
    } state_t;

    state_t              state_q;
    logic                ss_n_q;
    logic                busy_q;
    logic                frame_err_q;
    logic                miso_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [1:0]          cmd_q;
    logic [DATA_W-1:0]   shreg_q;
    logic [ADDR_W-1:0]   wptr_q;
    logic [ADDR_W-1:0]   rptr_q;
    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    logic [DATA_W-1:0]   payload_d;
    logic                mem_we_d;

    // Payload including the bit sampled at the current edge, so the last
    // payload bit takes effect at the very edge it is sampled.
    assign payload_d = {shreg_q[DATA_W-2:0], bus.mosi};

    // RAM write strobe: last payload edge of a WR_DATA frame that is not
    // being aborted or reset at the same edge.
    assign mem_we_d = !rst && (state_q == S_WRITE) && !bus.ss_n &&
                      (cnt_q == CNT_LAST) && (cmd_q == 2'b01);

    // Storage is not reset; its contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem[wptr_q] <= payload_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ss_n_q      <= 1'b0;  // master must raise ss_n before a frame can start
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
            cnt_q       <= '0;
            cmd_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
        end else begin
            ss_n_q      <= bus.ss_n;
            frame_err_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (ss_n_q && !bus.ss_n) begin
                        state_q <= S_CMD;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end

                S_CMD: begin
                    if (bus.ss_n) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        frame_err_q <= 1'b1;
                    end else begin
                        cmd_q <= {cmd_q[0], bus.mosi};
                        if (cnt_q == CNT_ONE) begin
                            cnt_q   <= '0;
                            state_q <= ({cmd_q[0], bus.mosi} == 2'b11) ? S_READ_PREP
                                                                        : S_WRITE;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end

                S_WRITE: begin
                    if (bus.ss_n) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        frame_err_q <= 1'b1;
                    end else begin
                        shreg_q <= payload_d;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= S_DONE;
                            case (cmd_q)
                                2'b00: wptr_q <= payload_d[ADDR_W-1:0];
                                2'b01: if (AUTO_INC != 0) wptr_q <= wptr_q + ADDR_W'(1);
                                2'b10: rptr_q <= payload_d[ADDR_W-1:0];
                                default: ;
                            endcase
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end

                S_READ_PREP: begin
                    if (bus.ss_n) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        frame_err_q <= 1'b1;
                    end else begin
                        // MSB goes straight to miso; shreg keeps the rest.
                        shreg_q <= mem[rptr_q];
                        miso_q  <= mem[rptr_q][DATA_W-1];
                        cnt_q   <= '0;
                        state_q <= S_READ_SHIFT;
                    end
                end

                S_READ_SHIFT: begin
                    if (bus.ss_n) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        frame_err_q <= 1'b1;
                        miso_q      <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        miso_q  <= 1'b0;
                        state_q <= S_DONE;
                        if (AUTO_INC != 0) rptr_q <= rptr_q + ADDR_W'(1);
                    end else begin
                        miso_q  <= shreg_q[DATA_W-2];
                        shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end

                S_DONE: begin
                    // Surplus bits of an overlong frame are ignored here.
                    if (bus.ss_n) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    miso_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.miso      = miso_q;
    assign bus.busy      = busy_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_ram_bridge.sv
module tb_spi_ram_bridge;

    logic clk;
    logic rst;
    logic ss_n_v;
    logic mosi_v;
    logic sel_b;
    logic miso_v;
    logic busy_v;
    logic ferr_v;

    int checks;
    int errors;
    int errp_a;
    logic busy_last;
    logic busy_after;

    spi_ram_bridge_if ifa ();
    spi_ram_bridge_if ifb ();

    // Only the selected instance sees a low ss_n; the other stays idle.
    assign ifa.ss_n = sel_b ? 1'b1 : ss_n_v;
    assign ifb.ss_n = sel_b ? ss_n_v : 1'b1;
    assign ifa.mosi = mosi_v;
    assign ifb.mosi = mosi_v;
    assign miso_v   = sel_b ? ifb.miso      : ifa.miso;
    assign busy_v   = sel_b ? ifb.busy      : ifa.busy;
    assign ferr_v   = sel_b ? ifb.frame_err : ifa.frame_err;

    spi_ram_bridge #(.DATA_W(8), .ADDR_W(8), .AUTO_INC(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    spi_ram_bridge #(.DATA_W(16), .ADDR_W(4), .AUTO_INC(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ifa.frame_err) errp_a <= errp_a + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Full frame on the selected instance; n = payload width.
    // Inputs change on falling edges, outputs sampled on falling edges.
    task automatic do_frame(input logic [1:0] cmd, input logic [15:0] payload,
                            input int n, input int extra, output logic [15:0] rd);
        rd = '0;
        @(negedge clk); ss_n_v = 1'b0; mosi_v = 1'b0;       // E0 next
        @(negedge clk); mosi_v = cmd[1];                    // E1
        @(negedge clk); mosi_v = cmd[0];                    // E2
        if (cmd == 2'b11) begin
            @(negedge clk); mosi_v = 1'b0;                  // after E2
            for (int k = 0; k < n; k++) begin
                @(negedge clk);                             // after E3+k
                rd[n-1-k] = miso_v;
            end
        end else begin
            for (int k = 0; k < n; k++) begin
                @(negedge clk); mosi_v = payload[n-1-k];    // E3+k
            end
        end
        for (int k = 0; k < extra; k++) begin
            @(negedge clk); mosi_v = ~mosi_v;
        end
        @(negedge clk);
        busy_last = busy_v;
        ss_n_v = 1'b1; mosi_v = 1'b0;
        @(negedge clk);
        busy_after = busy_v;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; ss_n_v = 1'b1; mosi_v = 1'b0; sel_b = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ifa.miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", ifa.miso); end
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", ifa.busy); end
        checks++; if (ifa.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", ifa.frame_err); end
        checks++; if (dut_a.wptr_q !== 8'h00) begin errors++; $display("FAIL reset_wptr: got %h expected 00", dut_a.wptr_q); end
        checks++; if (dut_a.rptr_q !== 8'h00) begin errors++; $display("FAIL reset_rptr: got %h expected 00", dut_a.rptr_q); end
    endtask

    task automatic test_basic();
        logic [15:0] rd;
        int e0;
        e0 = errp_a;
        do_frame(2'b00, 16'h0010, 8, 0, rd);
        do_frame(2'b01, 16'h00A5, 8, 0, rd);
        do_frame(2'b10, 16'h0010, 8, 0, rd);
        do_frame(2'b11, 16'h0000, 8, 0, rd);
        checks++; if (rd[7:0] !== 8'hA5) begin errors++; $display("FAIL basic_read: got %h expected a5", rd[7:0]); end
        checks++; if (dut_a.wptr_q !== 8'h11) begin errors++; $display("FAIL basic_wptr: got %h expected 11", dut_a.wptr_q); end
        checks++; if (dut_a.rptr_q !== 8'h11) begin errors++; $display("FAIL basic_rptr: got %h expected 11", dut_a.rptr_q); end
        checks++; if (errp_a !== e0) begin errors++; $display("FAIL basic_no_ferr: got %0d pulses expected 0", errp_a - e0); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rd;
        logic [7:0] exp_v [3];
        exp_v[0] = 8'h11; exp_v[1] = 8'h22; exp_v[2] = 8'h33;
        do_frame(2'b00, 16'h00FE, 8, 0, rd);
        for (int i = 0; i < 3; i++) do_frame(2'b01, {8'h00, exp_v[i]}, 8, 0, rd);
        checks++; if (dut_a.wptr_q !== 8'h01) begin errors++; $display("FAIL burst_wptr_wrap: got %h expected 01", dut_a.wptr_q); end
        do_frame(2'b10, 16'h00FE, 8, 0, rd);
        for (int i = 0; i < 3; i++) begin
            do_frame(2'b11, 16'h0000, 8, 0, rd);
            checks++;
            if (rd[7:0] !== exp_v[i]) begin errors++; $display("FAIL burst_read%0d: got %h expected %h", i, rd[7:0], exp_v[i]); end
        end
    endtask

    task automatic test_abort();
        logic [15:0] rd;
        int e0;
        do_frame(2'b00, 16'h0020, 8, 0, rd);
        do_frame(2'b01, 16'h003C, 8, 0, rd);
        do_frame(2'b00, 16'h0020, 8, 0, rd);
        e0 = errp_a;
        @(negedge clk); ss_n_v = 1'b0; mosi_v = 1'b0;      // E0
        @(negedge clk); mosi_v = 1'b0;                     // E1
        @(negedge clk); mosi_v = 1'b1;                     // E2
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); mosi_v = 1'b1;                 // E3..E7
        end
        @(negedge clk); ss_n_v = 1'b1;                     // abort at E8
        @(negedge clk);
        checks++; if (ifa.frame_err !== 1'b1) begin errors++; $display("FAIL abort_ferr_hi: got %b expected 1", ifa.frame_err); end
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", ifa.busy); end
        @(negedge clk);
        checks++; if (ifa.frame_err !== 1'b0) begin errors++; $display("FAIL abort_ferr_lo: got %b expected 0", ifa.frame_err); end
        checks++; if (dut_a.wptr_q !== 8'h20) begin errors++; $display("FAIL abort_wptr: got %h expected 20", dut_a.wptr_q); end
        do_frame(2'b10, 16'h0020, 8, 0, rd);
        do_frame(2'b11, 16'h0000, 8, 0, rd);
        checks++; if (rd[7:0] !== 8'h3C) begin errors++; $display("FAIL abort_mem_kept: got %h expected 3c", rd[7:0]); end
        do_frame(2'b01, 16'h0077, 8, 0, rd);
        do_frame(2'b10, 16'h0020, 8, 0, rd);
        do_frame(2'b11, 16'h0000, 8, 0, rd);
        checks++; if (rd[7:0] !== 8'h77) begin errors++; $display("FAIL abort_next_frame: got %h expected 77", rd[7:0]); end
        checks++; if (errp_a - e0 !== 1) begin errors++; $display("FAIL abort_pulse_count: got %0d expected 1", errp_a - e0); end
    endtask

    task automatic test_overlong();
        logic [15:0] rd;
        int e0;
        e0 = errp_a;
        do_frame(2'b00, 16'h0040, 8, 0, rd);
        do_frame(2'b01, 16'h005A, 8, 9, rd);               // 20 edges low
        checks++; if (busy_last !== 1'b1) begin errors++; $display("FAIL overlong_busy_hold: got %b expected 1", busy_last); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL overlong_busy_drop: got %b expected 0", busy_after); end
        checks++; if (dut_a.wptr_q !== 8'h41) begin errors++; $display("FAIL overlong_wptr: got %h expected 41", dut_a.wptr_q); end
        do_frame(2'b10, 16'h0040, 8, 0, rd);
        do_frame(2'b11, 16'h0000, 8, 0, rd);
        checks++; if (rd[7:0] !== 8'h5A) begin errors++; $display("FAIL overlong_data: got %h expected 5a", rd[7:0]); end
        checks++; if (errp_a !== e0) begin errors++; $display("FAIL overlong_no_ferr: got %0d pulses expected 0", errp_a - e0); end
    endtask

    task automatic test_reset_mid_read();
        logic [15:0] rd;
        logic seen_busy;
        do_frame(2'b10, 16'h0040, 8, 0, rd);
        @(negedge clk); ss_n_v = 1'b0; mosi_v = 1'b0;      // E0
        @(negedge clk); mosi_v = 1'b1;                     // E1
        @(negedge clk); mosi_v = 1'b1;                     // E2
        @(negedge clk); mosi_v = 1'b0;                     // after E2
        @(negedge clk);                                    // after E3
        @(negedge clk);                                    // after E4: bit6 of 0x5A
        checks++; if (ifa.miso !== 1'b1) begin errors++; $display("FAIL midread_shifting: got %b expected 1", ifa.miso); end
        rst = 1'b1;                                        // sampled at E5
        @(negedge clk);
        rst = 1'b0;
        checks++; if (ifa.miso !== 1'b0) begin errors++; $display("FAIL midread_miso: got %b expected 0", ifa.miso); end
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL midread_busy: got %b expected 0", ifa.busy); end
        checks++; if (dut_a.wptr_q !== 8'h00) begin errors++; $display("FAIL midread_wptr: got %h expected 00", dut_a.wptr_q); end
        checks++; if (dut_a.rptr_q !== 8'h00) begin errors++; $display("FAIL midread_rptr: got %h expected 00", dut_a.rptr_q); end
        seen_busy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ifa.busy !== 1'b0) seen_busy = 1'b1;
        end
        checks++; if (seen_busy !== 1'b0) begin errors++; $display("FAIL midread_no_restart: got %b expected 0", seen_busy); end
        ss_n_v = 1'b1;
        @(negedge clk);
        do_frame(2'b11, 16'h0000, 8, 0, rd);               // rptr = 0 after reset
        checks++; if (rd[7:0] !== 8'h33) begin errors++; $display("FAIL midread_after_read: got %h expected 33", rd[7:0]); end
    endtask

    task automatic test_narrow_noinc();
        logic [15:0] rd;
        sel_b = 1'b1;
        @(negedge clk);
        do_frame(2'b00, 16'hFFF3, 16, 0, rd);
        checks++; if (dut_b.wptr_q !== 4'h3) begin errors++; $display("FAIL narrow_wptr_load: got %h expected 3", dut_b.wptr_q); end
        do_frame(2'b01, 16'h1234, 16, 0, rd);
        do_frame(2'b01, 16'hBEEF, 16, 0, rd);
        checks++; if (dut_b.wptr_q !== 4'h3) begin errors++; $display("FAIL narrow_wptr_held: got %h expected 3", dut_b.wptr_q); end
        checks++; if (dut_b.mem[3] !== 16'hBEEF) begin errors++; $display("FAIL narrow_mem3: got %h expected beef", dut_b.mem[3]); end
        do_frame(2'b10, 16'h0003, 16, 0, rd);
        do_frame(2'b11, 16'h0000, 16, 0, rd);
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL narrow_read: got %h expected beef", rd); end
        checks++; if (dut_b.rptr_q !== 4'h3) begin errors++; $display("FAIL narrow_rptr_held: got %h expected 3", dut_b.rptr_q); end
        do_frame(2'b11, 16'h0000, 16, 0, rd);
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL narrow_reread: got %h expected beef", rd); end
        sel_b = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        errp_a = 0;
        busy_last = 1'b0;
        busy_after = 1'b0;
        rst = 1'b1;
        ss_n_v = 1'b1;
        mosi_v = 1'b0;
        sel_b = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_abort();
        test_overlong();
        test_reset_mid_read();
        test_narrow_noinc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_ram_bridge.md
# spi_ram_bridge

Parametrised SPI-slave-to-single-port-RAM bridge: a serial master drives command frames on `mosi` while `ss_n` is low. The block decodes them into write/read address loads, RAM writes and RAM reads, and returns read data on `miso`. It generalises the fixed 8-bit SPI+RAM pair to configurable data and address widths. Address pointers auto-increment, aborted frames are detected, and the whole path sits in one clock domain.

## Interface
- `DATA_W`, default 8: RAM word width and frame payload width.
- `ADDR_W`, default 8: address width; DEPTH = 2**ADDR_W; must satisfy ADDR_W <= DATA_W.
- `AUTO_INC`, default 1: 1 = pointer increments after each data access; 0 = pointers held.

- `clk`  in  1  single clock; serial bit clock and system clock are the same.
- `rst`  in  1  synchronous, active-high reset.
- `ss_n`  in  1  frame select, active low.
- `mosi`  in  1  serial data in, MSB first, sampled on rising `clk`.
- `miso`  out  1  serial read data, registered.
- `busy`  out  1  high whenever the FSM is not IDLE.
- `frame_err`  out  1  one-cycle pulse when a frame is aborted.

## Operation
- Frame: 2 command bits, then DATA_W payload bits, all MSB first.
- Commands:
  - 00 WR_ADDR: `wptr <= payload[ADDR_W-1:0]`.
  - 01 WR_DATA: `mem[wptr] <= payload`; then wptr+1 if AUTO_INC.
  - 10 RD_ADDR: `rptr <= payload[ADDR_W-1:0]`.
  - 11 RD_DATA: `mem[rptr]` is shifted out on `miso`; MOSI is ignored; then rptr+1 if AUTO_INC.
- Payload bits above ADDR_W are ignored for the address commands.
- `wptr` and `rptr` are independent ADDR_W-bit registers and wrap DEPTH-1 -> 0.
- FSM states: IDLE, CMD, WRITE, READ_PREP, READ_SHIFT, DONE.
  - IDLE -> CMD on frame start.
  - CMD -> WRITE after 2 bits when cmd != 11.
  - CMD -> READ_PREP when cmd == 11.
  - READ_PREP -> READ_SHIFT after 1 cycle.
  - WRITE / READ_SHIFT -> DONE on completion.
  - DONE -> IDLE when `ss_n` = 1.
- Frame start: the registered copy `ss_n_q` = 1 and the current `ss_n` = 0 (falling edge).
  - `ss_n` must be high for at least 1 cycle between frames.
- In DONE, extra bits with `ss_n` low are ignored; nothing is updated.
- Abort: `ss_n` sampled 1 in CMD, WRITE, READ_PREP or READ_SHIFT sends the FSM to IDLE and pulses `frame_err` for one cycle.
  - No memory write and no pointer change on abort.
- Memory contents are not reset.
- Reset values: state IDLE, `wptr` = `rptr` = 0, `miso` = 0, `busy` = 0, `frame_err` = 0, `ss_n_q` = 0.
  - Because `ss_n_q` resets to 0, a master holding `ss_n` low through reset starts no frame until `ss_n` has gone high.
- Reset mid-frame: the frame is discarded with no write and no pointer update; reset has priority over every other event.

## Timing
- Edge numbering: E0 is the edge detecting the frame start (IDLE -> CMD); MOSI is not sampled at E0.
- E1, E2: sample cmd[1], cmd[0].
- Write-type commands:
  - E3..E(2+DATA_W) sample payload bits DATA_W-1..0.
  - The effect (pointer load or RAM write plus increment) commits at E(2+DATA_W), using the bit sampled at that edge.
  - FSM enters DONE at the same edge.
- RD_DATA:
  - E2 -> READ_PREP.
  - At E3, shift register <= `mem[rptr]`; state READ_SHIFT.
  - `miso` carries bit DATA_W-1 after E3 and bit 0 after E(2+DATA_W); the master samples at E4..E(3+DATA_W).
  - At E(3+DATA_W): rptr increments (if AUTO_INC), state DONE, `miso` returns to 0.
- `miso` is 0 in every state except READ_SHIFT.
- Minimum `ss_n`-low length: 3+DATA_W edges for writes, 4+DATA_W for reads.
- A frame reading an address written by an earlier frame returns the new data (no read-after-write hazard across frames).
- `frame_err` is registered and asserted in the cycle after the abort edge.

## Test plan
- Defaults (DATA_W=8, ADDR_W=8, AUTO_INC=1). Sequence: WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA -> `miso` returns 10100101 on E4..E11; afterwards `wptr` = 0x11 and `rptr` = 0x11.
- Burst: WR_ADDR 0xFE, then WR_DATA 0x11, 0x22, 0x33 -> mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33 (wrap); a read burst from RD_ADDR 0xFE returns 0x11, 0x22, 0x33.
- Abort: raise `ss_n` after 5 payload bits of WR_DATA 0xFF to address 0x20 -> `frame_err` pulses once, mem[0x20] unchanged, `wptr` still 0x20, next full frame decodes correctly.
- Reset mid-read: assert `rst` at E5 of RD_DATA with `ss_n` held low -> `miso` = 0, `busy` = 0, pointers = 0; no frame starts until `ss_n` goes high then low.
- AUTO_INC=0, DATA_W=16, ADDR_W=4: WR_ADDR 0xFFF3 loads `wptr` = 3; two WR_DATA frames 0x1234 then 0xBEEF -> mem[3] = 0xBEEF; RD_DATA returns 0xBEEF with `rptr` unchanged.
- Overlong frame: hold `ss_n` low for 20 edges on WR_DATA 0x5A -> exactly one write of 0x5A, no `frame_err`, `busy` drops one cycle after `ss_n` rises.
